// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote, framing and parity checks
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   en_rx       receiver enable; dropping it mid-frame aborts without a done pulse
//   u_rx        asynchronous serial input, idle high
//   data        last received word, LSB first on the line
//   u_rx_done   one-cycle pulse when a frame completes; data and error flags valid with it
//   frame_err   stop bit voted 0
//   parity_err  parity mismatch (always 0 when parity is disabled)
//   busy        receiver is inside a frame
module uart_rx_os #(
  parameter int BAUD_DIV   = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_rx,
  input  logic                 u_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 u_rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int PW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s, rx_d;
  logic [PW-1:0]        pc;
  logic [SW-1:0]        sc;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 v0, v1;
  logic                 par_nxt;
  logic                 tick, vote_tick, wrap, voted, start_det, last_bit;

  // Prescaler and sample counter only run inside a frame, so tick is gated by state.
  assign tick      = (state != IDLE) && (pc == PW'(BAUD_DIV - 1));
  assign vote_tick = tick && (sc == SW'(M + 1));
  assign wrap      = tick && (sc == SW'(OVERSAMPLE - 1));
  // Third vote sample is rx_s at the vote tick itself.
  assign voted     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign start_det = en_rx && rx_d && !rx_s;
  assign last_bit  = (idx == IW'(DATA_BITS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_det) state_nxt = START;
      START: begin
        if (vote_tick && voted) state_nxt = IDLE;  // false start
        else if (wrap)          state_nxt = DATA;
      end
      DATA:    if (wrap && last_bit) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (wrap) state_nxt = STOP;
      STOP:    if (vote_tick) state_nxt = IDLE;   // re-arm mid stop bit
      default: state_nxt = IDLE;
    endcase
    if (!en_rx && state != IDLE) state_nxt = IDLE;
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Synchronizer, counters, vote capture and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      pc         <= '0;
      sc         <= '0;
      idx        <= '0;
      shift      <= '0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      par_nxt    <= 1'b0;
      data       <= '0;
      u_rx_done  <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_m      <= u_rx;
      rx_s      <= rx_m;
      rx_d      <= rx_s;
      u_rx_done <= 1'b0;

      if (state == IDLE) begin
        pc      <= '0;
        sc      <= '0;
        idx     <= '0;
        par_nxt <= 1'b0;
      end else begin
        pc <= tick ? '0 : pc + PW'(1);
        if (tick) sc <= wrap ? '0 : sc + SW'(1);
        if (tick && sc == SW'(M - 1)) v0 <= rx_s;
        if (tick && sc == SW'(M))     v1 <= rx_s;

        if (state == DATA) begin
          if (vote_tick) shift <= {voted, shift[DATA_BITS-1:1]};
          if (wrap && !last_bit) idx <= idx + IW'(1);
        end

        if (state == PARITY && vote_tick)
          par_nxt <= (^shift) ^ voted ^ (PARITY_ODD != 0);

        // An abort on the same cycle as the stop vote must not deliver the frame.
        if (state == STOP && vote_tick && en_rx) begin
          data       <= shift;
          frame_err  <= ~voted;
          parity_err <= (PARITY_EN != 0) ? par_nxt : 1'b0;
          u_rx_done  <= 1'b1;
        end
      end
    end
  end

endmodule
